// File: rtl/cfg_frame_loader.sv
// Config frame loader: address byte + FRAME_W/8 data bytes (LSB first) -> one-hot latch-enable pulse.
// Define CFG_LOADER_CRC_EN to require a trailing CRC-8 byte (poly 0x07, init 0x00) per frame.
module cfg_frame_loader #(
    parameter int FRAME_W    = 32,
    parameter int NUM_FRAMES = 16,
    parameter int WE_CYCLES  = 2
) (
    input  logic                  clk,
    input  logic                  rn,
    input  logic [7:0]            cfg_data,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    output logic [FRAME_W-1:0]    frame_data,
    output logic [NUM_FRAMES-1:0] frame_we,
    output logic                  busy,
    output logic                  err,
    input  logic                  err_clr,
    output logic [15:0]           frame_cnt
);

    localparam int NBYTES = FRAME_W / 8;
    localparam int CNT_W  = 6;
`ifdef CFG_LOADER_CRC_EN
    localparam int DISC_BYTES = NBYTES + 1;
`else
    localparam int DISC_BYTES = NBYTES;
`endif
    localparam logic [NUM_FRAMES-1:0] WE_ONE = NUM_FRAMES'(1);

    typedef enum logic [2:0] {
        IDLE,
        DATA,
`ifdef CFG_LOADER_CRC_EN
        CRC,
`endif
        DISCARD,
        SETUP,
        WE,
        HOLD
    } state_t;

    state_t                  state_q, state_d;
    logic [7:0]              addr_q, addr_d;
    logic [CNT_W-1:0]        byte_cnt_q, byte_cnt_d;
    logic [3:0]              we_cnt_q, we_cnt_d;
    logic [FRAME_W-1:0]      frame_data_q, frame_data_d;
    logic [NUM_FRAMES-1:0]   frame_we_q, frame_we_d;
    logic [15:0]             frame_cnt_q, frame_cnt_d;
    logic                    err_q, err_d;
    logic                    err_set;
    logic                    accept;
`ifdef CFG_LOADER_CRC_EN
    logic [7:0]              crc_q, crc_d;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc_in, input logic [7:0] din);
        logic [7:0] c;
        c = crc_in ^ din;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction
`endif

    // Ready is forced low while reset is asserted so no byte is taken in the reset cycle.
    assign cfg_ready = rn && (state_q == IDLE || state_q == DATA ||
`ifdef CFG_LOADER_CRC_EN
                              state_q == CRC ||
`endif
                              state_q == DISCARD);
    assign busy       = rn && (state_q != IDLE);
    assign accept     = cfg_valid && cfg_ready;
    assign frame_data = frame_data_q;
    assign frame_we   = frame_we_q;
    assign frame_cnt  = frame_cnt_q;
    assign err        = err_q;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d      = state_q;
        addr_d       = addr_q;
        byte_cnt_d   = byte_cnt_q;
        we_cnt_d     = we_cnt_q;
        frame_data_d = frame_data_q;
        frame_cnt_d  = frame_cnt_q;
        err_set      = 1'b0;
`ifdef CFG_LOADER_CRC_EN
        crc_d        = crc_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    byte_cnt_d = '0;
                    if ({1'b0, cfg_data} < 9'(NUM_FRAMES)) begin
                        addr_d  = cfg_data;
                        state_d = DATA;
`ifdef CFG_LOADER_CRC_EN
                        crc_d   = crc8_step(8'h00, cfg_data);
`endif
                    end else begin
                        err_set = 1'b1;
                        state_d = DISCARD;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    for (int b = 0; b < NBYTES; b++) begin
                        if (byte_cnt_q == CNT_W'(b)) frame_data_d[b*8 +: 8] = cfg_data;
                    end
`ifdef CFG_LOADER_CRC_EN
                    crc_d = crc8_step(crc_q, cfg_data);
`endif
                    if (byte_cnt_q == CNT_W'(NBYTES - 1)) begin
`ifdef CFG_LOADER_CRC_EN
                        state_d = CRC;
`else
                        state_d = SETUP;
`endif
                    end else begin
                        byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    end
                end
            end
`ifdef CFG_LOADER_CRC_EN
            CRC: begin
                if (accept) begin
                    if (cfg_data == crc_q) begin
                        state_d = SETUP;
                    end else begin
                        err_set = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
`endif
            DISCARD: begin
                if (accept) begin
                    if (byte_cnt_q == CNT_W'(DISC_BYTES - 1)) state_d = IDLE;
                    else byte_cnt_d = byte_cnt_q + CNT_W'(1);
                end
            end
            SETUP: begin
                we_cnt_d = '0;
                state_d  = WE;
            end
            WE: begin
                if (we_cnt_q == 4'(WE_CYCLES - 1)) begin
                    state_d     = HOLD;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end else begin
                    we_cnt_d = we_cnt_q + 4'd1;
                end
            end
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Set wins over a same-cycle clear.
        err_d      = (err_q && !err_clr) || err_set;
        // Enables are registered from the next state so the latches see a glitch-free pulse.
        frame_we_d = (state_d == WE) ? (WE_ONE << addr_q) : '0;
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
        if (!rn) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            byte_cnt_q   <= '0;
            we_cnt_q     <= '0;
            frame_data_q <= '0;
            frame_we_q   <= '0;
            frame_cnt_q  <= '0;
            err_q        <= 1'b0;
`ifdef CFG_LOADER_CRC_EN
            crc_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            byte_cnt_q   <= byte_cnt_d;
            we_cnt_q     <= we_cnt_d;
            frame_data_q <= frame_data_d;
            frame_we_q   <= frame_we_d;
            frame_cnt_q  <= frame_cnt_d;
            err_q        <= err_d;
`ifdef CFG_LOADER_CRC_EN
            crc_q        <= crc_d;
`endif
        end
    end

endmodule

// File: tb/tb_cfg_frame_loader.sv
// Self-checking bench for cfg_frame_loader: directed sequences, a vector table and a random
// frame stream scored against a frame-level model of the latch array, counters and error flag.
module tb_cfg_frame_loader;

    localparam int FRAME_W    = 32;
    localparam int NUM_FRAMES = 16;
    localparam int WE_CYCLES  = 2;

    logic                  clk = 1'b0;
    logic                  rn = 1'b0;
    logic [7:0]            cfg_data = 8'h00;
    logic                  cfg_valid = 1'b0;
    logic                  cfg_ready;
    logic [FRAME_W-1:0]    frame_data;
    logic [NUM_FRAMES-1:0] frame_we;
    logic                  busy;
    logic                  err;
    logic                  err_clr = 1'b0;
    logic [15:0]           frame_cnt;

    cfg_frame_loader #(
        .FRAME_W   (FRAME_W),
        .NUM_FRAMES(NUM_FRAMES),
        .WE_CYCLES (WE_CYCLES)
    ) dut (
        .clk       (clk),
        .rn        (rn),
        .cfg_data  (cfg_data),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .frame_data(frame_data),
        .frame_we  (frame_we),
        .busy      (busy),
        .err       (err),
        .err_clr   (err_clr),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int checks_total  = 0;
    int checks_passed = 0;

    logic [NUM_FRAMES-1:0] seen_we   = '0;
    int                    we_cycles = 0;
    logic [FRAME_W-1:0]    latch_mem [NUM_FRAMES];

    typedef struct {
        logic [7:0]            addr;
        logic [31:0]           data;
        logic                  exp_err;
        logic [NUM_FRAMES-1:0] exp_we;
        logic [31:0]           exp_data;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behaves like the config latches: capture frame_data whenever an enable is high.
    always @(negedge clk) begin
        if (frame_we != '0) begin
            we_cycles++;
            seen_we |= frame_we;
            check("we_onehot", 64'($countones(frame_we)), 64'd1);
            for (int i = 0; i < NUM_FRAMES; i++) begin
                if (frame_we[i]) latch_mem[i] = frame_data;
            end
        end
    end

`ifdef CFG_LOADER_CRC_EN
    // CRC-8 as the remainder of message * x^8 divided by x^8+x^2+x+1.
    function automatic logic [7:0] ref_crc(input logic [7:0] addr, input logic [31:0] data);
        logic [47:0] m;
        m = {addr, data[7:0], data[15:8], data[23:16], data[31:24], 8'h00};
        for (int i = 47; i >= 8; i--) begin
            if (m[i]) m[i -: 9] = m[i -: 9] ^ 9'h107;
        end
        return m[7:0];
    endfunction
`endif

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        cfg_valid = 1'b0;
        repeat (gap) tick();
        cfg_data  = b;
        cfg_valid = 1'b1;
        n = 0;
        while (!cfg_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            checks_total++;
            $display("FAIL send_byte_timeout: cfg_ready=%0b required 1", cfg_ready);
        end
        tick();
    endtask

    // gap_mode: 0 back-to-back, 1 valid low one cycle before every byte, 2 random 0..2 cycle gaps.
    task automatic send_frame(input logic [7:0] addr, input logic [31:0] data, input int gap_mode,
                              input logic [7:0] crc_xor);
        logic [7:0] bytes [6];
        int nb;
        bytes[0] = addr;
        for (int i = 0; i < 4; i++) bytes[i+1] = data[i*8 +: 8];
        nb = 5;
`ifdef CFG_LOADER_CRC_EN
        bytes[5] = ref_crc(addr, data) ^ crc_xor;
        nb = 6;
`else
        if (crc_xor != 8'h00) $display("note: crc_xor ignored without CRC");
`endif
        for (int i = 0; i < nb; i++) begin
            send_byte(bytes[i], gap_mode == 0 ? 0 : (gap_mode == 1 ? 1 : int'($urandom_range(0, 2))));
        end
        cfg_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        check("wait_idle_bound", 64'(n < 50), 64'd1);
    endtask

    // Called at the cycle after the last byte; walks SETUP, WE x WE_CYCLES, HOLD, IDLE.
    task automatic check_pulse(input logic [7:0] addr, input logic [31:0] data, input logic [15:0] cnt_before);
        logic [NUM_FRAMES-1:0] exp_we;
        exp_we = NUM_FRAMES'(1) << addr;
        check("setup_we", 64'(frame_we), 64'd0);
        check("setup_ready", 64'(cfg_ready), 64'd0);
        check("setup_busy", 64'(busy), 64'd1);
        check("setup_data", 64'(frame_data), 64'(data));
        tick();
        for (int k = 0; k < WE_CYCLES; k++) begin
            check("we_pulse", 64'(frame_we), 64'(exp_we));
            check("we_data", 64'(frame_data), 64'(data));
            tick();
        end
        check("hold_we", 64'(frame_we), 64'd0);
        check("hold_ready", 64'(cfg_ready), 64'd0);
        check("hold_data", 64'(frame_data), 64'(data));
        check("hold_cnt", 64'(frame_cnt), 64'(cnt_before + 16'd1));
        tick();
        check("idle_ready", 64'(cfg_ready), 64'd1);
        check("idle_busy", 64'(busy), 64'd0);
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [6];
        int   n;
        logic [15:0]           cnt_model;
        logic                  err_model;
        logic [31:0]           data_model;
        logic [31:0]           mem_model [NUM_FRAMES];
        logic [NUM_FRAMES-1:0] written;

        vecs[0] = '{8'h00, 32'hDEADBEEF, 1'b0, 16'h0001, 32'hDEADBEEF};
        vecs[1] = '{8'h0F, 32'h01234567, 1'b0, 16'h8000, 32'h01234567};
        vecs[2] = '{8'h10, 32'hFFFFFFFF, 1'b1, 16'h0000, 32'h01234567};
        vecs[3] = '{8'hFF, 32'h00000000, 1'b1, 16'h0000, 32'h01234567};
        vecs[4] = '{8'h07, 32'hA5A5A5A5, 1'b0, 16'h0080, 32'hA5A5A5A5};
        vecs[5] = '{8'h08, 32'h00000000, 1'b0, 16'h0100, 32'h00000000};

        // Reset state
        tick();
        tick();
        check("rst_ready", 64'(cfg_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_we", 64'(frame_we), 64'd0);
        check("rst_data", 64'(frame_data), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_cnt", 64'(frame_cnt), 64'd0);
        rn = 1'b1;
        #1;
        check("rst_release_ready", 64'(cfg_ready), 64'd1);
        tick();

        // Basic frame to address 3 with exact pulse timing
        send_frame(8'h03, 32'h11223344, 0, 8'h00);
        check_pulse(8'h03, 32'h11223344, 16'd0);
        check("basic_cnt", 64'(frame_cnt), 64'd1);

        // Out-of-range address is discarded and flags err
        seen_we = '0;
        send_frame(8'h10, 32'h55667788, 0, 8'h00);
        check("oor_ready", 64'(cfg_ready), 64'd1);
        check("oor_busy", 64'(busy), 64'd0);
        check("oor_err", 64'(err), 64'd1);
        check("oor_seen_we", 64'(seen_we), 64'd0);
        check("oor_cnt", 64'(frame_cnt), 64'd1);
        check("oor_data", 64'(frame_data), 64'h11223344);
        clear_err();
        check("oor_err_clr", 64'(err), 64'd0);

        // Valid toggled every other cycle
        send_frame(8'h00, 32'hCAFEF00D, 1, 8'h00);
        n = 0;
        while (!cfg_ready && n < 20) begin
            tick();
            n++;
        end
        check("gap_ready_low_cycles", 64'(n), 64'(2 + WE_CYCLES));
        check("gap_data", 64'(frame_data), 64'hCAFEF00D);
        check("gap_cnt", 64'(frame_cnt), 64'd2);
        check("gap_latch0", 64'(latch_mem[0]), 64'hCAFEF00D);

        // err_clr in the same cycle as a bad address: set wins
        tick();
        cfg_data  = 8'h20;
        cfg_valid = 1'b1;
        err_clr   = 1'b1;
        tick();
        err_clr   = 1'b0;
        cfg_valid = 1'b0;
        check("setwins_err", 64'(err), 64'd1);
`ifdef CFG_LOADER_CRC_EN
        for (int i = 0; i < 5; i++) send_byte(8'h5A, 0);
`else
        for (int i = 0; i < 4; i++) send_byte(8'h5A, 0);
`endif
        cfg_valid = 1'b0;
        check("setwins_idle", 64'(busy), 64'd0);
        clear_err();

        // Reset during the first WE cycle
        rn = 1'b0;
        tick();
        rn = 1'b1;
        tick();
        send_frame(8'h05, 32'h0BADBEEF, 0, 8'h00);
        tick();
        check("rstwe_we_active", 64'(frame_we), 64'h0020);
        rn = 1'b0;
        tick();
        check("rstwe_we_drop", 64'(frame_we), 64'd0);
        check("rstwe_cnt", 64'(frame_cnt), 64'd0);
        check("rstwe_data", 64'(frame_data), 64'd0);
        rn = 1'b1;
        tick();
        send_frame(8'h06, 32'h76543210, 0, 8'h00);
        check_pulse(8'h06, 32'h76543210, 16'd0);
        check("rstwe_latch6", 64'(latch_mem[6]), 64'h76543210);

`ifdef CFG_LOADER_CRC_EN
        // CRC good then CRC corrupted
        seen_we = '0;
        send_frame(8'h01, 32'hDDCCBBAA, 0, 8'h00);
        check_pulse(8'h01, 32'hDDCCBBAA, 16'd1);
        check("crc_good_err", 64'(err), 64'd0);
        seen_we = '0;
        send_frame(8'h01, 32'hDDCCBBAA, 0, 8'h01);
        wait_idle();
        check("crc_bad_err", 64'(err), 64'd1);
        check("crc_bad_seen_we", 64'(seen_we), 64'd0);
        check("crc_bad_cnt", 64'(frame_cnt), 64'd2);
        clear_err();
`endif

        // Table of single frames
        for (int v = 0; v < 6; v++) begin
            clear_err();
            seen_we   = '0;
            we_cycles = 0;
            send_frame(vecs[v].addr, vecs[v].data, 0, 8'h00);
            wait_idle();
            tick();
            check("vec_err", 64'(err), 64'(vecs[v].exp_err));
            check("vec_seen_we", 64'(seen_we), 64'(vecs[v].exp_we));
            check("vec_we_cycles", 64'(we_cycles), 64'(vecs[v].exp_we != '0 ? WE_CYCLES : 0));
            check("vec_data", 64'(frame_data), 64'(vecs[v].exp_data));
        end

        // Random frame stream against the frame-level model
        rn = 1'b0;
        tick();
        rn = 1'b1;
        tick();
        cnt_model  = '0;
        err_model  = 1'b0;
        data_model = '0;
        written    = '0;
        for (int i = 0; i < NUM_FRAMES; i++) mem_model[i] = '0;
        for (int f = 0; f < 60; f++) begin
            logic [7:0]  a;
            logic [31:0] d;
            logic        crc_bad;
            logic        loads;
            a       = 8'($urandom_range(0, 19));
            d       = $urandom;
            crc_bad = 1'b0;
`ifdef CFG_LOADER_CRC_EN
            crc_bad = ($urandom_range(0, 5) == 0);
`endif
            if ($urandom_range(0, 4) == 0) begin
                clear_err();
                err_model = 1'b0;
            end
            seen_we   = '0;
            we_cycles = 0;
            send_frame(a, d, 2, crc_bad ? 8'h80 : 8'h00);
            wait_idle();
            tick();
            loads = (a < 8'(NUM_FRAMES)) && !crc_bad;
            if (a < 8'(NUM_FRAMES)) data_model = d;
            if (!loads) err_model = 1'b1;
            if (loads) begin
                cnt_model    = cnt_model + 16'd1;
                mem_model[a] = d;
                written[a]   = 1'b1;
            end
            check("rnd_cnt", 64'(frame_cnt), 64'(cnt_model));
            check("rnd_err", 64'(err), 64'(err_model));
            check("rnd_data", 64'(frame_data), 64'(data_model));
            check("rnd_seen_we", 64'(seen_we), loads ? 64'(NUM_FRAMES'(1) << a) : 64'd0);
            check("rnd_we_cycles", 64'(we_cycles), 64'(loads ? WE_CYCLES : 0));
        end
        for (int i = 0; i < NUM_FRAMES; i++) begin
            if (written[i]) check("rnd_latch", 64'(latch_mem[i]), 64'(mem_model[i]));
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/cfg_frame_loader.md
CFG_FRAME_LOADER -- requirements
Module: cfg_frame_loader

Interface
REQ-001 The block SHALL have parameter FRAME_W, default 32, meaning config frame width in bits; legal values are multiples of 8, from 8 to 256.
REQ-002 The block SHALL have parameter NUM_FRAMES, default 16, meaning the number of latch frames addressed (2..256).
REQ-003 The block SHALL have parameter WE_CYCLES, default 2, meaning the width of the latch-enable pulse in clock cycles (1..15).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have port rn, input, 1 bit: synchronous active-low reset.
REQ-006 The block SHALL have ports cfg_data (input, 8 bits), cfg_valid (input, 1 bit) and cfg_ready (output, 1 bit): the bitstream byte stream; a byte transfers on a clock edge where cfg_valid and cfg_ready are both high.
REQ-007 The block SHALL have port frame_data, output, FRAME_W bits: the data bus driving the d inputs of the config latches.
REQ-008 The block SHALL have port frame_we, output, NUM_FRAMES bits: one-hot latch enables, one bit per frame.
REQ-009 The block SHALL have port busy, output, 1 bit, high in any state other than IDLE.
REQ-010 The block SHALL have ports err (output, 1 bit, sticky error flag) and err_clr (input, 1 bit, clears err).
REQ-011 The block SHALL have port frame_cnt, output, 16 bits: count of frames written; the count wraps at 0xFFFF.

Function
REQ-012 The block SHALL use the states IDLE, DATA, CRC (macro only), DISCARD, SETUP, WE and HOLD.
REQ-013 cfg_ready SHALL be high in IDLE, DATA, CRC and DISCARD, and low in SETUP, WE and HOLD.
REQ-014 In IDLE, an accepted byte is the frame address. If it is below NUM_FRAMES, the address is latched and the state goes to DATA; otherwise err is set and the state goes to DISCARD.
REQ-015 DATA SHALL accept exactly FRAME_W/8 bytes, least-significant byte first, assembled directly in frame_data.
REQ-016 After the last data byte, the state goes to CRC if the macro is defined, otherwise to SETUP.
REQ-017 DISCARD SHALL consume FRAME_W/8 bytes (plus 1 CRC byte if the macro is defined) without changing frame_data, then return to IDLE.
REQ-018 For a last byte accepted at edge N: SETUP occupies cycle N+1 with frame_we all-zero; frame_we[addr] is high for cycles N+2 .. N+1+WE_CYCLES; HOLD occupies cycle N+2+WE_CYCLES with frame_we zero; the state is IDLE with cfg_ready high at cycle N+3+WE_CYCLES.
REQ-019 frame_data SHALL be stable from SETUP through HOLD inclusive.
REQ-020 At most one frame_we bit SHALL be high at any time.
REQ-021 frame_cnt SHALL increment by 1 on the transition WE->HOLD.
REQ-022 err_clr SHALL clear err; if a set event and err_clr occur in the same cycle, err is set (set wins).
REQ-023 Gaps in cfg_valid SHALL stall the state machine without losing position within the frame.

Reset
REQ-024 When rn is low at a clock edge: state goes to IDLE, frame_we=0, frame_data=0, err=0, frame_cnt=0, busy=0, cfg_ready=0 in the reset cycle.
REQ-025 cfg_ready SHALL return high on the first cycle after rn goes high.
REQ-026 Reset mid-frame, including during WE, SHALL drop frame_we the next cycle and discard the partial frame.

Configuration
REQ-027 With CFG_LOADER_CRC_EN defined, the block SHALL run a CRC-8 (poly 0x07, init 0x00, MSB first) over the address and data bytes, and the next byte is the CRC.
REQ-028 With CFG_LOADER_CRC_EN defined, a CRC match SHALL go to SETUP; a mismatch SHALL set err and go to IDLE without any frame_we pulse, and frame_cnt is not incremented.
REQ-029 Without CFG_LOADER_CRC_EN, the block SHALL contain no CRC state and no CRC byte is expected.

Verification
REQ-030 Reset, then stream 0x03,0x44,0x33,0x22,0x11 -> frame_data=0x11223344; frame_we=0x0008 for exactly 2 cycles, starting 2 cycles after the last byte; frame_cnt=1.
REQ-031 Address 0x10 followed by 4 bytes -> err=1; frame_we stays 0; ready in IDLE after the 4th byte; frame_cnt unchanged; err_clr pulse -> err=0.
REQ-032 cfg_valid toggled every other cycle through a frame to address 0 -> same result as the back-to-back case; cfg_ready low exactly 4 cycles (SETUP+2×WE+HOLD).
REQ-033 rn low during the first WE cycle -> frame_we=0 next cycle; frame_cnt=0; a following complete frame loads correctly.
REQ-034 Macro defined: frame 0x01,0xAA,0xBB,0xCC,0xDD plus correct CRC -> one pulse on frame_we[1]; same frame with CRC byte XOR 0x01 -> err=1 and no pulse.
REQ-035 err_clr asserted in the same cycle an out-of-range address is accepted -> err=1.
